multicycle_control_unit: RTL and testbench

Parametrised multi-cycle successor to the single-cycle MIPS control decoder. A registered FSM sequences each instruction through fetch, decode, execute, memory and write-back. It adds a memory ready/wait handshake with timeout, a trap state, and a retired-instruction counter. It sits between the instruction register (opcode) and the multi-cycle datapath, driving every datapath mux and enable.

---
 rtl/multicycle_control_unit_if.sv | 52 +++++
 rtl/multicycle_control_unit.sv | 206 ++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_unit_if
// Description : Bundle between the multi-cycle control FSM and the datapath /
//               memory side. "master" is the control unit (drives every mux
//               select and enable); "slave" is the datapath (supplies the IR
//               opcode and the memory ready handshake).
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_control_unit_if #(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 2,
  parameter int CNT_W    = 32
);
  // Datapath -> control
  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;

  // Control -> datapath
  logic                pc_write;
  logic                pc_write_cond;
  logic                iord;
  logic                mem_read;
  logic                mem_write;
  logic                ir_write;
  logic                reg_dst;
  logic                mem_to_reg;
  logic                reg_write;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [ALUOP_W-1:0]  alu_op;
  logic [1:0]          pc_source;
  logic                trap;
  logic [1:0]          trap_cause;
  logic [3:0]          state;
  logic [CNT_W-1:0]    instr_retired;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, trap, trap_cause, state, instr_retired
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, trap, trap_cause, state, instr_retired
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_unit
// Description : Multi-cycle MIPS control FSM (fetch/decode/execute/memory/
//               write-back) with memory wait handshake and timeout, trap
//               state and retired-instruction counter.
//               Optional feature macro: CTRL_JUMP_EN (enables the j / JUMP
//               state; without it opcode 000010 is illegal).
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_unit #(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 2,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  multicycle_control_unit_if.master bus
);

  localparam int WAIT_W = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  localparam bit TIMEOUT_EN = (WAIT_MAX > 0);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(WAIT_MAX);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  typedef enum logic [3:0] {
    S_RESET   = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXEC    = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_JUMP    = 4'd10,
    S_ADDI_EX = 4'd11,
    S_ADDI_WB = 4'd12,
    S_TRAP    = 4'd15
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        cause_q, cause_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  logic [5:0]        w_op;
  logic              w_stall;
  logic              w_timeout;
  logic              w_retire;
  logic [1:0]        w_alu_op;

  assign w_op = bus.opcode[5:0];

  // A memory-wait state is stalling whenever the handshake is not ready.
  assign w_stall   = ((state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR))
                     && !bus.mem_ready;
  // Counter already at the limit and still not ready: give up.
  assign w_timeout = TIMEOUT_EN && w_stall && (wait_q == WAIT_LIM);
  // Counter only runs while stalled in place; any state change or ready clears it.
  assign wait_d    = (w_stall && (state_d == state_q)) ? wait_q + WAIT_W'(1) : '0;
  // An instruction retires on the edge that returns its last state to FETCH.
  assign w_retire  = (state_d == S_FETCH) &&
                     (state_q inside {S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_JUMP, S_ADDI_WB});
  assign retired_d = w_retire ? retired_q + CNT_W'(1) : retired_q;

  // State, trap cause, wait counter and retired count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RESET;
      cause_q   <= 2'b00;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  // Next-state selection and Moore decode of every datapath control.
  always_comb begin
    state_d           = state_q;
    cause_d           = cause_q;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.iord          = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.pc_source     = 2'b00;
    bus.trap          = 1'b0;
    w_alu_op          = 2'b00;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        // IR and PC+4 are captured only on the cycle the fetch completes
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        bus.alu_src_b = 2'b11;
        case (w_op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDI_EX;
`ifdef CTRL_JUMP_EN
          OP_J:         state_d = S_JUMP;
`endif
          default: begin
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MEMADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        state_d       = (w_op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        bus.mem_read = 1'b1;
        bus.iord     = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        state_d        = S_FETCH;
      end
      S_MEMWR: begin
        bus.mem_write = 1'b1;
        bus.iord      = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH;
      end
      S_EXEC: begin
        bus.alu_src_a = 1'b1;
        w_alu_op      = 2'b10;
        state_d       = S_ALUWB;
      end
      S_ALUWB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
        state_d       = S_FETCH;
      end
      S_BRANCH: begin
        bus.alu_src_a     = 1'b1;
        w_alu_op          = 2'b01;
        bus.pc_source     = 2'b01;
        bus.pc_write_cond = 1'b1;
        state_d           = S_FETCH;
      end
      S_ADDI_EX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        state_d       = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        bus.reg_write = 1'b1;
        state_d       = S_FETCH;
      end
`ifdef CTRL_JUMP_EN
      S_JUMP: begin
        bus.pc_write  = 1'b1;
        bus.pc_source = 2'b10;
        state_d       = S_FETCH;
      end
`endif
      S_TRAP: bus.trap = 1'b1;
      // Unused encodings recover through a clean restart
      default: state_d = S_RESET;
    endcase
    if (w_timeout) begin
      state_d = S_TRAP;
      cause_d = CAUSE_TIMEOUT;
    end
  end

  assign bus.alu_op        = ALUOP_W'(w_alu_op);
  assign bus.trap_cause    = cause_q;
  assign bus.state         = state_q;
  assign bus.instr_retired = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control_unit
// Description : Self-checking bench for multicycle_control_unit: directed
//               vector table, randomized run against an instruction-level
//               reference model, and hand-written trap/reset sequences.
//               Honours CTRL_JUMP_EN in its expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_unit;

  localparam int OPCODE_W = 6;
  localparam int ALUOP_W  = 3;
  localparam int WAIT_MAX = 3;
  localparam int CNT_W    = 3;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] AD = 6'b001000, BQ = 6'b000100, JP = 6'b000010;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  multicycle_control_unit_if #(.OPCODE_W(OPCODE_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) bus ();

  multicycle_control_unit #(
    .OPCODE_W(OPCODE_W), .ALUOP_W(ALUOP_W), .WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  logic [17:0] act_out;
  assign act_out = {bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_read, bus.mem_write,
                    bus.ir_write, bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.alu_src_a,
                    bus.alu_src_b, bus.alu_op, bus.pc_source, bus.trap};

  // Expected control outputs of a state, straight from the state/output table.
  function automatic logic [17:0] exp_out(input int st, input logic mr);
    logic pcw, pcwc, iord, mrd, mwr, irw, rdst, m2r, rw, asa, trp;
    logic [1:0] asb, aop, psrc;
    {pcw, pcwc, iord, mrd, mwr, irw, rdst, m2r, rw, asa, trp} = '0;
    asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (st)
      1:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      2:  asb = 2'b11;
      3:  begin asa = 1; asb = 2'b10; end
      4:  begin mrd = 1; iord = 1; end
      5:  begin rw = 1; m2r = 1; end
      6:  begin mwr = 1; iord = 1; end
      7:  begin asa = 1; aop = 2'b10; end
      8:  begin rw = 1; rdst = 1; end
      9:  begin asa = 1; aop = 2'b01; psrc = 2'b01; pcwc = 1; end
      10: begin pcw = 1; psrc = 2'b10; end
      11: begin asa = 1; asb = 2'b10; end
      12: rw = 1;
      15: trp = 1;
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw, rdst, m2r, rw, asa, asb, 1'b0, aop, psrc, trp};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input int st, input logic [17:0] eo,
                           input int cnt, input int cause);
    chk({tag, " state"},   64'(bus.state),         64'(st));
    chk({tag, " outputs"}, 64'(act_out),           64'(eo));
    chk({tag, " retired"}, 64'(bus.instr_retired), 64'(cnt));
    chk({tag, " cause"},   64'(bus.trap_cause),    64'(cause));
  endtask

  // ---------------- instruction-level reference model ----------------
  int m_state, m_wait, m_cnt, m_cause;
  int m_path[$];

  task automatic model_reset();
    m_state = 0; m_wait = 0; m_cnt = 0; m_cause = 0;
    m_path.delete();
  endtask

  // One clock of the model: each instruction is a list of phases after DECODE.
  task automatic model_step(input logic [5:0] op, input logic mr);
    if (m_state == 15) return;
    if (m_state == 0) begin m_state = 1; return; end
    if ((m_state == 1 || m_state == 4 || m_state == 6) && !mr) begin
      if (WAIT_MAX > 0 && m_wait == WAIT_MAX) begin
        m_state = 15; m_cause = 2; m_wait = 0;
      end else begin
        m_wait++;
      end
      return;
    end
    m_wait = 0;
    if (m_state == 1) begin
      m_state = 2;
    end else if (m_state == 2) begin
      m_path.delete();
      case (op)
        LW: m_path = '{3, 4, 5};
        SW: m_path = '{3, 6};
        RT: m_path = '{7, 8};
        AD: m_path = '{11, 12};
        BQ: m_path = '{9};
`ifdef CTRL_JUMP_EN
        JP: m_path = '{10};
`endif
        default: ;
      endcase
      if (m_path.size() == 0) begin
        m_state = 15; m_cause = 1;
      end else begin
        m_state = m_path.pop_front();
      end
    end else if (m_path.size() != 0) begin
      m_state = m_path.pop_front();
    end else begin
      m_state = 1;
      m_cnt   = (m_cnt + 1) % (1 << CNT_W);
    end
  endtask

  // Called at posedge+1; leaves the bench at posedge+1 with the DUT in RESET.
  task automatic do_reset();
    rst_n = 1'b0; bus.mem_ready = 1'b0; bus.opcode = '0;
    @(negedge clk);
    check_all("reset", 0, 18'h0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic run_cycle(input logic [5:0] op, input logic mr, input string tag);
    bus.opcode = op; bus.mem_ready = mr;
    @(negedge clk);
    check_all(tag, m_state, exp_out(m_state, mr), m_cnt, m_cause);
    model_step(op, mr);
    @(posedge clk); #1;
  endtask

  // Short directed sequence: per-cycle ready bits and expected state nibbles.
  task automatic hand_seq(input string name, input logic [5:0] op, input int n,
                          input logic [15:0] mrv, input logic [63:0] sts, input int cause);
    for (int k = 0; k < n; k++) begin
      bus.opcode = op; bus.mem_ready = mrv[k];
      @(negedge clk);
      chk($sformatf("%s c%0d state", name, k), 64'(bus.state), 64'(sts[4*k +: 4]));
      if (k == n - 1) chk({name, " cause"}, 64'(bus.trap_cause), 64'(cause));
      @(posedge clk); #1;
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [5:0] op;
    logic       mr;
    int         st;
    int         cnt;
    int         cause;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input logic [5:0] op, input logic mr, input int st,
                              input int cnt, input int cause);
    vecs.push_back('{op, mr, st, cnt, cause});
  endfunction

  function automatic logic [5:0] pick_op();
    int r;
    r = int'($urandom_range(0, 31));
    if (r < 9)  return LW;
    if (r < 14) return SW;
    if (r < 19) return RT;
    if (r < 24) return AD;
    if (r < 29) return BQ;
    if (r < 31) return JP;
    return 6'b111111;
  endfunction

  logic [5:0] cur_op;
  logic       mr_r;

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; bus.opcode = '0; bus.mem_ready = 1'b0;
    model_reset();

    // RESET cycle, lw, sw with 3 waits, R, addi, beq, lw, then j
    add(RT, 1, 0, 0, 0);
    add(LW, 1, 1, 0, 0); add(LW, 1, 2, 0, 0); add(LW, 1, 3, 0, 0);
    add(LW, 1, 4, 0, 0); add(LW, 1, 5, 0, 0);
    add(SW, 1, 1, 1, 0); add(SW, 1, 2, 1, 0); add(SW, 1, 3, 1, 0);
    add(SW, 0, 6, 1, 0); add(SW, 0, 6, 1, 0); add(SW, 0, 6, 1, 0); add(SW, 1, 6, 1, 0);
    add(RT, 1, 1, 2, 0); add(RT, 1, 2, 2, 0); add(RT, 1, 7, 2, 0); add(RT, 1, 8, 2, 0);
    add(AD, 1, 1, 3, 0); add(AD, 1, 2, 3, 0); add(AD, 1, 11, 3, 0); add(AD, 1, 12, 3, 0);
    add(BQ, 1, 1, 4, 0); add(BQ, 1, 2, 4, 0); add(BQ, 1, 9, 4, 0);
    add(LW, 1, 1, 5, 0); add(LW, 1, 2, 5, 0); add(LW, 1, 3, 5, 0);
    add(LW, 1, 4, 5, 0); add(LW, 1, 5, 5, 0);
    add(JP, 1, 1, 6, 0); add(JP, 1, 2, 6, 0);
`ifdef CTRL_JUMP_EN
    add(JP, 1, 10, 6, 0); add(RT, 0, 1, 7, 0);
`else
    add(JP, 1, 15, 6, 1); add(JP, 1, 15, 6, 1);
`endif

    @(posedge clk); #1;
    do_reset();
    foreach (vecs[i]) begin
      bus.opcode = vecs[i].op; bus.mem_ready = vecs[i].mr;
      @(negedge clk);
      check_all($sformatf("vec%0d", i), vecs[i].st, exp_out(vecs[i].st, vecs[i].mr),
                vecs[i].cnt, vecs[i].cause);
      @(posedge clk); #1;
    end

    // Randomized run against the reference model
    do_reset();
    cur_op = LW;
    for (int i = 0; i < 3000; i++) begin
      if (m_state == 15 && $urandom_range(0, 3) == 0) begin
        do_reset();
      end else begin
        if (m_state == 1) cur_op = pick_op();
        mr_r = ($urandom_range(0, 9) < 7);
        run_cycle(cur_op, mr_r, $sformatf("rnd%0d", i));
      end
    end

    // Fetch timeout: 3 waits tolerated, 4th stalled cycle traps
    do_reset();
    hand_seq("fetch_tmo", LW, 6, 16'h0000, 64'hF11110, 2);
    do_reset();
    hand_seq("fetch_rdy4", LW, 6, 16'h0010, 64'h211110, 0);

    // Illegal opcode traps, holds, then async reset clears everything
    do_reset();
    hand_seq("illegal", 6'h3F, 4, 16'hFFFF, 64'h0000F210, 1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk($sformatf("trap hold%0d state", k), 64'(bus.state), 64'd15);
      chk($sformatf("trap hold%0d outputs", k), 64'(act_out), 64'(exp_out(15, 1'b1)));
      @(posedge clk); #1;
    end
    #2; rst_n = 1'b0; #1;
    check_all("async_reset_trap", 0, 18'h0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();

    // Reset pulse in the middle of a stalled MEMRD
    for (int k = 0; k < 5; k++) run_cycle(RT, 1'b1, $sformatf("pre_r%0d", k));
    for (int k = 0; k < 3; k++) run_cycle(LW, 1'b1, $sformatf("pre_lw%0d", k));
    bus.opcode = LW; bus.mem_ready = 1'b0;
    #1;
    chk("memrd strobe before reset", 64'(bus.mem_read), 64'd1);
    chk("memrd retired before reset", 64'(bus.instr_retired), 64'd1);
    rst_n = 1'b0; #1;
    check_all("async_reset_memrd", 0, 18'h0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 3; k++) run_cycle(LW, 1'b1, $sformatf("post_rst%0d", k));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
